contador_modn: RTL



---
 rtl/contador_modn.sv | 59 +++++
 1 files changed

// File: rtl/contador_modn.sv
// Single-digit modulo/BCD counter with load clamp, up/down counting,
// terminal-count cascade output and optional hold-at-zero when counting down.
module contador_modn #(
   parameter int WIDTH        = 4,
   parameter int MOD          = 10,
   parameter bit STOP_AT_ZERO = 1'b0
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             loadn,
   input  logic             en,
   input  logic             up,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             zero
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   // One extra bit so MOD == 2**WIDTH still compares correctly against data.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic             at_max;
   logic             at_zero;

   always_comb begin
      at_max  = (q_q == MAX_VAL);
      at_zero = (q_q == '0);
      q_d     = q_q;
      if (!loadn) begin
         q_d = ({1'b0, data} >= MOD_EXT) ? MAX_VAL : data;
      end else if (en) begin
         if (up) begin
            q_d = at_max ? '0 : (q_q + ONE);
         end else if (at_zero) begin
            q_d = STOP_AT_ZERO ? '0 : MAX_VAL;
         end else begin
            q_d = q_q - ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q    = q_q;
   assign zero = at_zero;
   // Depends only on this digit's state and inputs, so chaining tc->en never loops.
   assign tc   = en & loadn & ((up & at_max) | (~up & at_zero));

endmodule
